// File: rtl/bist_pkg.sv
// Shared types and polynomial step functions for the BIST pattern controller.
// Functions work on a MAX_W-wide container; callers pass the live width.
package bist_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CAPTURE,
    S_DONE
  } bist_state_e;

  function automatic logic [MAX_W-1:0] width_mask(input int width);
    width_mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
  endfunction

  // Galois step: shift left, fold the falling-off MSB back in through poly.
  function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] state,
                                                 input logic [MAX_W-1:0] poly,
                                                 input int               width);
    logic [MAX_W-1:0] r;
    r = (state << 1) ^ (state[width-1] ? poly : '0);
    lfsr_next = r & width_mask(width);
  endfunction

  function automatic logic [MAX_W-1:0] misr_next(input logic [MAX_W-1:0] state,
                                                 input logic [MAX_W-1:0] poly,
                                                 input logic [MAX_W-1:0] data,
                                                 input int               width);
    misr_next = lfsr_next(state, poly, width) ^ (data & width_mask(width));
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Parametrised Galois LFSR with synchronous seed load and step enable.
// A zero seed would lock the register, so it is replaced by 1.
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = 5'b01001,
  parameter logic [WIDTH-1:0] SEED  = 5'b00001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_state
);

  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] r_state;
  logic [MAX_W-1:0] w_next_full;
  logic             w_unused_hi;

  assign w_next_full = lfsr_next(MAX_W'(r_state), MAX_W'(POLY), WIDTH);
  assign w_unused_hi = ^w_next_full[MAX_W-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED_EFF;
    end else if (i_load) begin
      r_state <= SEED_EFF;
    end else if (i_en) begin
      r_state <= w_next_full[WIDTH-1:0];
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/bist_pattern_ctrl.sv
// BIST controller: LFSR patterns onto a combinational CUT, MISR compaction of
// the responses, and a final signature compare against golden_sig.
module bist_pattern_ctrl
  import bist_pkg::*;
#(
  parameter int               N_IN      = 5,
  parameter int               N_OUT     = 3,
  parameter int               N_PAT     = 6,
  parameter logic [N_IN-1:0]  LFSR_POLY = 5'b01001,
  parameter logic [N_IN-1:0]  LFSR_SEED = 5'b00001,
  parameter logic [N_OUT-1:0] MISR_POLY = 3'b011
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [N_OUT-1:0]           golden_sig,
  output logic [N_IN-1:0]            cut_in,
  input  logic [N_OUT-1:0]           cut_out,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [N_OUT-1:0]           signature,
  output logic [$clog2(N_PAT+1)-1:0] pat_cnt
);

  localparam int CNT_W = $clog2(N_PAT + 1);

  bist_state_e      r_state;
  bist_state_e      w_state_nxt;
  logic             w_lfsr_load;
  logic             w_lfsr_en;
  logic [N_IN-1:0]  w_lfsr;
  logic [N_OUT-1:0] r_misr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pass;
  logic [MAX_W-1:0] w_misr_full;
  logic [N_OUT-1:0] w_misr_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_last;
  logic             w_active;
  logic             w_unused_hi;

  bist_lfsr #(
    .WIDTH (N_IN),
    .POLY  (LFSR_POLY),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_lfsr_load),
    .i_en    (w_lfsr_en),
    .o_state (w_lfsr)
  );

  assign w_misr_full = misr_next(MAX_W'(r_misr), MAX_W'(MISR_POLY), MAX_W'(cut_out), N_OUT);
  assign w_misr_nxt  = w_misr_full[N_OUT-1:0];
  assign w_unused_hi = ^w_misr_full[MAX_W-1:N_OUT];
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_last      = (w_cnt_inc == CNT_W'(N_PAT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // start is only honoured when no run is in flight; the LFSR steps once per capture.
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_load = 1'b0;
    w_lfsr_en   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_APPLY;
          w_lfsr_load = 1'b1;
        end
      end
      S_APPLY: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_lfsr_en   = 1'b1;
        w_state_nxt = w_last ? S_DONE : S_APPLY;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misr <= '0;
      r_cnt  <= '0;
      r_pass <= 1'b0;
    end else if (w_lfsr_load) begin
      r_misr <= '0;
      r_cnt  <= '0;
      r_pass <= 1'b0;
    end else if (r_state == S_CAPTURE) begin
      r_misr <= w_misr_nxt;
      r_cnt  <= w_cnt_inc;
      if (w_last) begin
        r_pass <= (w_misr_nxt == golden_sig);
      end
    end
  end

  assign w_active  = (r_state == S_APPLY) || (r_state == S_CAPTURE);
  assign cut_in    = w_active ? w_lfsr : '0;
  assign busy      = w_active;
  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;
  assign signature = r_misr;
  assign pat_cnt   = r_cnt;

endmodule

// File: doc/bist_pattern_ctrl.md
Name: bist_pattern_ctrl

Overview:
- Parametrised on-chip successor to the file-driven, fixed-six-pattern stimulus flow used for the ISCAS-style combinational CUTs (add2 and peers).
- Generates N_PAT pseudo-random patterns with an LFSR and drives them onto a combinational CUT.
- Compacts CUT responses in a MISR and compares the final signature against a golden value.
- Sits beside any netlist from the circuit library; the CUT is wired between cut_in and cut_out.

Parameters:
- N_IN, 5: CUT input width = LFSR width; must be ≥2.
- N_OUT, 3: CUT output width = MISR width; must be ≥2.
- N_PAT, 6: patterns per run; must be ≥1.
- LFSR_POLY, 5'b01001: Galois feedback mask; bit k = coefficient of x^k, x^N_IN term implied (default x^5+x^3+1).
- LFSR_SEED, 5'b00001: initial LFSR state; a value of 0 is replaced by 1.
- MISR_POLY, 3'b011: MISR feedback mask, same encoding (default x^3+x+1).

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: begin a run; sampled only in IDLE or DONE.
- golden_sig, input, N_OUT: expected signature; sampled at the final capture.
- cut_in, output, N_IN: pattern driven to the CUT.
- cut_out, input, N_OUT: CUT response, combinational from cut_in.
- busy, output, 1: high in APPLY or CAPTURE.
- done, output, 1: high in DONE.
- pass, output, 1: signature == golden_sig; valid while done is high.
- signature, output, N_OUT: current MISR state.
- pat_cnt, output, $clog2(N_PAT+1): number of patterns captured so far.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; cut_in=0, busy=0, done=0, pass=0, signature=0, pat_cnt=0; LFSR loaded with the seed.
- FSM states: IDLE, APPLY, CAPTURE, DONE. All outputs are registered or decoded from state.
- IDLE: cut_in=0. When start=1, load LFSR with the seed, clear MISR and pat_cnt, go to APPLY.
- APPLY: cut_in=LFSR. One settle cycle for the CUT. Go to CAPTURE.
- CAPTURE: cut_in is held at the LFSR value. On the edge leaving CAPTURE:
  - MISR <= ((MISR<<1) ^ (MISR[N_OUT-1] ? MISR_POLY : 0)) ^ cut_out.
  - LFSR <= (LFSR<<1) ^ (LFSR[N_IN-1] ? LFSR_POLY : 0).
  - pat_cnt increments.
  - If the incremented count equals N_PAT: go to DONE and register pass = (new MISR == golden_sig). Otherwise go to APPLY.
- DONE: cut_in=0. done, pass and signature hold. start=1 restarts exactly as from IDLE; done drops on that edge.
- Latency: a run takes 2*N_PAT cycles from the start-sampling edge to done rising.
- start is ignored while busy; there is no abort except rst.
- N_PAT=1: a single APPLY/CAPTURE pair, then DONE.
- All arithmetic is modulo 2 within the stated widths; pat_cnt never exceeds N_PAT.
- Reset mid-run: immediate return to reset values; no partial signature is retained.

Decomposition:
- Shared package bist_pkg:
  - State enum.
  - Function lfsr_next(state, poly, width).
  - Function misr_next(state, poly, data, width).
- One natural sub-module: bist_lfsr (parametrised Galois LFSR with load/enable). It is reused by the future scan-chain pattern generator.
- The MISR is inline.

Test Plan:
- Loopback, defaults: cut_out=cut_in[2:0], golden_sig=3'b110, start pulse.
  - cut_in sequence 00001, 00010, 00100, 01000, 10000, 01001.
  - Signature progression 001, 000, 100, 011, 110, 110.
  - done rises 12 cycles after start; pass=1, pat_cnt=6.
- Same stimulus with golden_sig=3'b111 → signature=110, done=1, pass=0.
- cut_out tied to 000, golden_sig=000 → signature=000, pass=1. Also check cut_in=0 in IDLE and DONE.
- start pulsed again during CAPTURE of pattern 3 → ignored; run completes on schedule with signature 110.
- rst asserted during APPLY of pattern 4 → same cycle: busy=0, cut_in=0, signature=0, pat_cnt=0. A new start then reproduces signature 110.
- Restart from DONE, plus an N_PAT=1 build:
  - Restart from DONE → identical sequence and signature 110.
  - N_PAT=1 build with loopback → done after 2 cycles, signature=001.
